// File: rtl/axi_lite_pkg.sv
// Shared AXI-lite definitions: response codes, initiator state encoding,
// and the MMIO request/response bundles exchanged with the core.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int MMIO_ADDR_W = 64;
    localparam int MMIO_DATA_W = 64;
    localparam int MMIO_STRB_W = MMIO_DATA_W / 8;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WB,
        RA,
        RD
    } state_e;

    typedef struct packed {
        logic                   we;
        logic [MMIO_ADDR_W-1:0] addr;
        logic [MMIO_DATA_W-1:0] wdata;
        logic [MMIO_STRB_W-1:0] wstrb;
    } mmio_req_t;

    typedef struct packed {
        logic [MMIO_DATA_W-1:0] rdata;
        logic                   err;
    } mmio_rsp_t;

    // Anything other than OKAY is reported to the core as an error.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp != RESP_OKAY;
    endfunction

endpackage

// File: rtl/axi_lite_mmio_master.sv
// AXI-lite initiator: converts one outstanding core MMIO request into a
// single AXI-lite read or write and returns a one-cycle completion.
module axi_lite_mmio_master
    import axi_lite_pkg::*;
#(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 1024
) (
    input  logic                clk,
    input  logic                rst,
    // core MMIO port
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_wstrb,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    // AXI-lite write channels
    output logic [ADDR_W-1:0]   awaddr,
    output logic                awvalid,
    input  logic                awready,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic                wvalid,
    input  logic                wready,
    input  logic [1:0]          bresp,
    input  logic                bvalid,
    output logic                bready,
    // AXI-lite read channels
    output logic [ADDR_W-1:0]   araddr,
    output logic                arvalid,
    input  logic                arready,
    input  logic [DATA_W-1:0]   rdata,
    input  logic [1:0]          rresp,
    input  logic                rvalid,
    output logic                rready
);

    // The counter fires when it holds TIMEOUT-1 on a cycle with no handshake,
    // i.e. after TIMEOUT consecutive stalled cycles.
    localparam bit              TO_EN    = (TIMEOUT != 0);
    localparam int              CNT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = TO_EN ? CNT_W'(TIMEOUT - 1) : '0;

    state_e              state_q, state_d;
    logic                aw_done_q, aw_done_d;
    logic                w_done_q, w_done_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs, any_hs, busy, timeout_hit;

    // Channel controls are pure decodes of the registered state, so they
    // all fall together on reset or timeout.
    assign req_ready = (state_q == IDLE);
    assign awvalid   = (state_q == WR) && !aw_done_q;
    assign wvalid    = (state_q == WR) && !w_done_q;
    assign bready    = (state_q == WB);
    assign arvalid   = (state_q == RA);
    assign rready    = (state_q == RD);

    // Slaves only ever see the latched request, never the live core inputs.
    assign awaddr    = addr_q;
    assign araddr    = addr_q;
    assign wdata     = wdata_q;
    assign wstrb     = wstrb_q;

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    assign aw_hs  = awvalid && awready;
    assign w_hs   = wvalid  && wready;
    assign b_hs   = bready  && bvalid;
    assign ar_hs  = arvalid && arready;
    assign r_hs   = rready  && rvalid;
    assign any_hs = aw_hs || w_hs || b_hs || ar_hs || r_hs;
    assign busy   = (state_q != IDLE);

    assign timeout_hit = TO_EN && busy && !any_hs && (cnt_q == CNT_LAST);

    // State register and latched request/response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Next-state, handshake tracking, stall counter and completion.
    always_comb begin
        state_d     = state_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (req_valid) begin
                    addr_d    = req_addr;
                    wdata_d   = req_wdata;
                    wstrb_d   = req_wstrb;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = req_we ? WR : RA;
                end
            end
            WR: begin
                // AW and W complete independently, in either order.
                if (aw_hs) aw_done_d = 1'b1;
                if (w_hs)  w_done_d  = 1'b1;
                if (aw_done_d && w_done_d) state_d = WB;
            end
            WB: begin
                if (b_hs) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = resp_is_err(bresp);
                    state_d     = IDLE;
                end
            end
            RA: begin
                if (ar_hs) state_d = RD;
            end
            RD: begin
                if (r_hs) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = rdata;
                    rsp_err_d   = resp_is_err(rresp);
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Stall counter restarts on any channel handshake.
        if (busy) begin
            if (any_hs) cnt_d = '0;
            else        cnt_d = cnt_q + CNT_W'(1);
        end

        // Abandon a stuck transaction: error completion, drop everything.
        if (timeout_hit) begin
            state_d     = IDLE;
            cnt_d       = '0;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = '0;
            rsp_err_d   = 1'b1;
        end
    end

endmodule
